// File: rtl/rvv_lane_sequencer.sv
// rvv_lane_sequencer: LANES-wide vector integer ALU with vl clamp and tail-undisturbed write-back.
// Define RVV_SEQ_MASK_EN to add the vm/v0 mask-undisturbed ports.
module rvv_lane_sequencer #(
    parameter int VLEN  = 128,
    parameter int LANES = 4,
    parameter int VLW   = $clog2(VLEN / 8) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    output logic            ready,
    input  logic [2:0]      opcode,
    input  logic [2:0]      op_type,
    input  logic [2:0]      vsew,
    input  logic [VLW-1:0]  vl,
    input  logic [VLEN-1:0] vs1,
    input  logic [VLEN-1:0] vs2,
    input  logic [31:0]     scalar,
    input  logic [VLEN-1:0] vd_old,
    output logic [VLEN-1:0] vd,
    output logic            done,
    output logic            illegal
`ifdef RVV_SEQ_MASK_EN
    ,
    input  logic            vm,
    input  logic [VLEN-1:0] v0
`endif
);
    localparam int BW = VLW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_done;
    logic            r_illegal;
    logic [VLEN-1:0] r_vd;
    logic [VLEN-1:0] r_vs1;
    logic [VLEN-1:0] r_vs2;
    logic [2:0]      r_opcode;
    logic [2:0]      r_optype;
    logic [1:0]      r_sew;
    logic [31:0]     r_scalar;
    logic [VLW-1:0]  r_vl_eff;
    logic [BW-1:0]   r_base;
`ifdef RVV_SEQ_MASK_EN
    logic            r_vm;
    logic [VLEN-1:0] r_v0;
`endif

    logic            w_illegal;
    logic [VLW-1:0]  w_vlmax;
    logic [VLW-1:0]  w_vl_eff;
    logic [63:0]     w_smask;
    logic [63:0]     w_scal;
    logic [VLEN-1:0] w_vd_nxt;
    logic [BW-1:0]   w_base_nxt;
    logic            w_wr  [LANES];
    logic [63:0]     w_res [LANES];
    logic [31:0]     w_off [LANES];

    function automatic logic [63:0] f_sext(input logic [63:0] x, input logic [1:0] sew);
        unique case (sew)
            2'd0:    return {{56{x[7]}}, x[7:0]};
            2'd1:    return {{48{x[15]}}, x[15:0]};
            2'd2:    return {{32{x[31]}}, x[31:0]};
            default: return x;
        endcase
    endfunction

    // Operands arrive zero-extended to 64 bits; signed max works on sign-extended copies.
    function automatic logic [63:0] f_alu(input logic [2:0] op, input logic [1:0] sew,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [5:0]  sh;
        sa = f_sext(a, sew);
        sb = f_sext(b, sew);
        sh = b[5:0] & 6'((7'd8 << sew) - 7'd1);
        case (op)
            3'b000:  f_alu = a + b;
            3'b001:  f_alu = a - b;
            3'b010:  f_alu = a & b;
            3'b011:  f_alu = a | b;
            3'b100:  f_alu = a ^ b;
            3'b101:  f_alu = (a < b) ? a : b;
            3'b110:  f_alu = ($signed(sa) > $signed(sb)) ? a : b;
            default: f_alu = a << sh;
        endcase
    endfunction

    assign w_illegal = (vsew > 3'd3) ||
                       !(op_type == 3'b001 || op_type == 3'b010 || op_type == 3'b100);
    assign w_vlmax    = VLW'(VLEN / 8) >> vsew[1:0];
    assign w_vl_eff   = (vl > w_vlmax) ? w_vlmax : vl;
    assign w_base_nxt = r_base + BW'(LANES);

    always_comb begin
        unique case (r_sew)
            2'd0:    w_smask = 64'hFF;
            2'd1:    w_smask = 64'hFFFF;
            2'd2:    w_smask = 64'hFFFF_FFFF;
            default: w_smask = '1;
        endcase
    end

    always_comb begin
        w_scal = '0;
        if (r_optype[2]) begin
            w_scal = {{59{r_scalar[4]}}, r_scalar[4:0]};
        end else if (r_optype[1]) begin
            w_scal = (r_sew == 2'd3) ? f_sext({32'b0, r_scalar}, 2'd2) : {32'b0, r_scalar};
        end
        w_scal = w_scal & w_smask;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [BW-1:0] w_e;
        logic [63:0]   w_a;
        logic [63:0]   w_b;
        logic          w_mok;
        assign w_e      = r_base + BW'(g);
        assign w_off[g] = 32'(w_e) << (32'd3 + 32'(r_sew));
        assign w_a      = 64'(r_vs2 >> w_off[g]) & w_smask;
        assign w_b      = r_optype[0] ? (64'(r_vs1 >> w_off[g]) & w_smask) : w_scal;
`ifdef RVV_SEQ_MASK_EN
        assign w_mok    = r_vm || (|(r_v0 & (VLEN'(1) << w_e)));
`else
        assign w_mok    = 1'b1;
`endif
        assign w_wr[g]  = (w_e < BW'(r_vl_eff)) && w_mok;
        assign w_res[g] = f_alu(r_opcode, r_sew, w_a, w_b) & w_smask;
    end

    always_comb begin
        w_vd_nxt = r_vd;
        for (int i = 0; i < LANES; i++) begin
            if (w_wr[i]) begin
                w_vd_nxt = (w_vd_nxt & ~(VLEN'(w_smask) << w_off[i])) |
                           (VLEN'(w_res[i]) << w_off[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_vd      <= '0;
            r_base    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vs1    <= vs1;
                        r_vs2    <= vs2;
                        r_opcode <= opcode;
                        r_optype <= op_type;
                        r_sew    <= vsew[1:0];
                        r_scalar <= scalar;
                        r_vl_eff <= w_vl_eff;
`ifdef RVV_SEQ_MASK_EN
                        r_vm     <= vm;
                        r_v0     <= v0;
`endif
                        r_vd     <= vd_old;
                        r_base   <= '0;
                        r_ready  <= 1'b0;
                        if (w_illegal || w_vl_eff == '0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= w_illegal;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_vd   <= w_vd_nxt;
                    r_base <= w_base_nxt;
                    if (w_base_nxt >= BW'(r_vl_eff)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign vd      = r_vd;

endmodule
